multicycle_control: RTL and testbench

//  Main FSM sequencer for the multi-cycle MIPS datapath. Issues per-state mux selects and write strobes.
//  ISA subset: R-type, beq, lw, sw, addi.

---
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main FSM sequencer for the multi-cycle MIPS datapath (R-type, lw, sw, beq, addi).
// Emits per-state mux selects and write strobes; memory accesses wait on mem_ready.
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             instr_retired,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t stateQ, stateD;
  logic   memRdy;

  // Ungated control word; every port is masked by rst_n below.
  logic       pcWriteC, pcWriteCondC, iorDC, memReadC, memWriteC, irWriteC;
  logic       memtoRegC, regDstC, regWriteC, aluSrcAC, retireC, illegalC;
  logic [1:0] pcSourceC, aluSrcBC, aluOpC;

  logic [CNT_W-1:0] cntQ;

  assign memRdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= FETCH;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = FETCH;
    case (stateQ)
      FETCH:  stateD = memRdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     stateD = EXEC;
          OP_LW, OP_SW: stateD = MEMADR;
          OP_BEQ:       stateD = BRANCH;
          OP_ADDI:      stateD = ADDIEX;
          default:      stateD = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW)      stateD = MEMRD;
        else if (opcode == OP_SW) stateD = MEMWR;
        else                      stateD = FETCH;
      end
      MEMRD:  stateD = memRdy ? MEMWB : MEMRD;
      MEMWB:  stateD = FETCH;
      MEMWR:  stateD = memRdy ? FETCH : MEMWR;
      EXEC:   stateD = RWB;
      RWB:    stateD = FETCH;
      BRANCH: stateD = FETCH;
      ADDIEX: stateD = ADDIWB;
      ADDIWB: stateD = FETCH;
      default: stateD = FETCH;
    endcase
  end

  always_comb begin
    pcWriteC     = 1'b0;
    pcWriteCondC = 1'b0;
    pcSourceC    = 2'b00;
    iorDC        = 1'b0;
    memReadC     = 1'b0;
    memWriteC    = 1'b0;
    irWriteC     = 1'b0;
    memtoRegC    = 1'b0;
    regDstC      = 1'b0;
    regWriteC    = 1'b0;
    aluSrcAC     = 1'b0;
    aluSrcBC     = 2'b00;
    aluOpC       = 2'b00;
    retireC      = 1'b0;
    illegalC     = 1'b0;
    case (stateQ)
      FETCH: begin
        // PC+4 is written only on the completing cycle, so a stalled fetch never double-increments.
        memReadC = 1'b1;
        aluSrcBC = 2'b01;
        aluOpC   = 2'b10;
        irWriteC = memRdy;
        pcWriteC = memRdy;
      end
      DECODE: begin
        aluSrcBC = 2'b11;
        aluOpC   = 2'b10;
        illegalC = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI});
      end
      MEMADR: begin
        aluSrcAC = 1'b1;
        aluSrcBC = 2'b10;
        aluOpC   = 2'b10;
      end
      MEMRD: begin
        iorDC    = 1'b1;
        memReadC = 1'b1;
      end
      MEMWB: begin
        memtoRegC = 1'b1;
        regWriteC = 1'b1;
        retireC   = 1'b1;
      end
      MEMWR: begin
        iorDC     = 1'b1;
        memWriteC = 1'b1;
        retireC   = memRdy;
      end
      EXEC: begin
        aluSrcAC = 1'b1;
      end
      RWB: begin
        regDstC   = 1'b1;
        regWriteC = 1'b1;
        retireC   = 1'b1;
      end
      BRANCH: begin
        aluSrcAC     = 1'b1;
        aluOpC       = 2'b01;
        pcWriteCondC = 1'b1;
        pcSourceC    = 2'b01;
        retireC      = 1'b1;
      end
      ADDIEX: begin
        aluSrcAC = 1'b1;
        aluSrcBC = 2'b10;
        aluOpC   = 2'b10;
      end
      ADDIWB: begin
        regWriteC = 1'b1;
        retireC   = 1'b1;
      end
      default: ;
    endcase
  end

  // Asynchronous masking: nothing leaves the block while rst_n is low, even mid-cycle.
  assign PCWrite       = rst_n & pcWriteC;
  assign PCWriteCond   = rst_n & pcWriteCondC;
  assign PCSource      = {2{rst_n}} & pcSourceC;
  assign IorD          = rst_n & iorDC;
  assign MemRead       = rst_n & memReadC;
  assign MemWrite      = rst_n & memWriteC;
  assign IRWrite       = rst_n & irWriteC;
  assign MemtoReg      = rst_n & memtoRegC;
  assign RegDst        = rst_n & regDstC;
  assign RegWrite      = rst_n & regWriteC;
  assign ALUSrcA       = rst_n & aluSrcAC;
  assign ALUSrcB       = {2{rst_n}} & aluSrcBC;
  assign ALUOp         = {2{rst_n}} & aluOpC;
  assign state         = {4{rst_n}} & stateQ;
  assign instr_retired = rst_n & retireC;
  assign illegal_op    = rst_n & illegalC;
  assign retired_cnt   = {CNT_W{rst_n}} & cntQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cntQ <= '0;
    else if (retireC && (cntQ != '1))    cntQ <= cntQ + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle control words; a monitor compares them.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA, instr_retired, illegal_op;
  logic [1:0]    PCSource, ALUSrcB, ALUOp;
  logic [3:0]    state;
  logic [CW-1:0] retired_cnt;

  multicycle_control #(.MEM_WAIT_EN(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state),
    .instr_retired(instr_retired), .illegal_op(illegal_op),
    .retired_cnt(retired_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [25:0] act;
  assign act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, state,
                instr_retired, illegal_op, retired_cnt};

  logic [25:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          chkEn = 1'b0;
  logic [CW-1:0] mCnt = '0;

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_ILL} kind_t;

  // Control word each state is documented to drive.
  function automatic logic [25:0] ctl(int st, bit mr, bit ill, bit ret, logic [CW-1:0] cnt);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
    {pcs, asb, aop} = '0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; aop = 2'b10; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; aop = 2'b10; end
      2:  begin asa = 1; asb = 2'b10; aop = 2'b10; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin asa = 1; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; aop = 2'b10; end
      10: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop,
            4'(st), ret, ill, cnt};
  endfunction

  function automatic kind_t classify(logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      default:   return K_ILL;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(int st, bit mr, bit ill, bit ret);
    exp_q.push_back(ctl(st, mr, ill, ret, mCnt));
    if (ret && mCnt != '1) mCnt = mCnt + 1'b1;
  endtask

  // One cycle in a state whose outputs ignore mem_ready: drive it randomly.
  task automatic plain(int st, bit ret);
    mem_ready = 1'($urandom_range(0, 1));
    expect_cycle(st, 1'b0, 1'b0, ret);
    tick();
  endtask

  task automatic mem_wait(int st, int waits, bit retOnDone);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      expect_cycle(st, 1'b0, 1'b0, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    expect_cycle(st, 1'b1, 1'b0, retOnDone);
    tick();
  endtask

  task automatic run_instr(logic [5:0] op, int fetchWaits, int memWaits);
    kind_t k;
    k = classify(op);
    opcode = 6'($urandom);
    mem_wait(0, fetchWaits, 1'b0);
    opcode = op;
    mem_ready = 1'($urandom_range(0, 1));
    expect_cycle(1, 1'b0, k == K_ILL, 1'b0);
    tick();
    case (k)
      K_R:    begin plain(6, 1'b0); plain(7, 1'b1); end
      K_LW:   begin plain(2, 1'b0); mem_wait(3, memWaits, 1'b0); plain(4, 1'b1); end
      K_SW:   begin plain(2, 1'b0); mem_wait(5, memWaits, 1'b1); end
      K_BEQ:  plain(8, 1'b1);
      K_ADDI: begin plain(9, 1'b0); plain(10, 1'b1); end
      default: ;
    endcase
  endtask

  task automatic check_zero(string name);
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL %s got=%h expected=0", name, act);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && chkEn) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL ctl_underflow got=%h expected=<none>", act);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL ctl_word t=%0t got=%h expected=%h", $time, act, e);
        end
      end
    end
  end

  logic [5:0] legalOps[5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000};

  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1 check_zero("reset_outputs");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chkEn = 1'b1;

    run_instr(6'b100011, 0, 0);   // lw, no waits
    run_instr(6'b101011, 0, 3);   // sw, 3 wait cycles in MEMWR
    run_instr(6'b000000, 2, 0);   // R-type, 2 fetch waits
    run_instr(6'b000100, 0, 0);   // beq
    run_instr(6'b111111, 0, 0);   // illegal

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom); while (classify(op) != K_ILL);
      end else begin
        op = legalOps[$urandom_range(0, 4)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    for (int n = 0; n < 17; n++) run_instr(6'b001000, 0, 0);

    // lw abandoned by reset while waiting in MEMRD
    opcode = 6'($urandom);
    mem_wait(0, 0, 1'b0);
    opcode = 6'b100011;
    plain(1, 1'b0);
    opcode = 6'b100011;
    plain(2, 1'b0);
    mem_ready = 1'b0;
    expect_cycle(3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chkEn = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain_before_reset got=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    rst_n = 1'b0;
    #1 check_zero("async_reset_in_memrd");
    mem_ready = 1'b1;
    @(negedge clk);
    check_zero("reset_held_after_memrd");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mCnt = '0;
    chkEn = 1'b1;
    run_instr(6'b001000, 1, 0);
    run_instr(6'b000100, 0, 0);
    chkEn = 1'b0;

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_left_over got=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
